// File: rtl/counter_multimode.sv
// counter_multimode: WIDTH-bit modulo-MOD_VALUE counter, binary/Gray, up/down.
// Define COUNTER_SAT_EN to saturate at the terminal value instead of wrapping.
module counter_multimode #(
  parameter int WIDTH     = 3,
  parameter int MOD_VALUE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idx_next;
  logic [WIDTH-1:0] count_next;
  logic             up;
  logic             tc_next;
  logic             wrap_next;
  logic             err_next;

  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    up        = ~mode[0];
    if (load) begin
      if (load_val > LAST) begin
        idx_next = LAST;
        err_next = 1'b1;
      end else begin
        idx_next = load_val;
      end
    end else if (en && up) begin
      if (idx == LAST) begin
`ifdef COUNTER_SAT_EN
        idx_next  = idx;
`else
        idx_next  = '0;
        wrap_next = 1'b1;
`endif
      end else begin
        idx_next = idx + ONE;
      end
    end else if (en) begin
      if (idx == '0) begin
`ifdef COUNTER_SAT_EN
        idx_next  = idx;
`else
        idx_next  = LAST;
        wrap_next = 1'b1;
`endif
      end else begin
        idx_next = idx - ONE;
      end
    end
    // Terminal value depends on the direction sampled this edge
    tc_next    = up ? (idx_next == LAST) : (idx_next == '0);
    count_next = mode[1] ? (idx_next ^ (idx_next >> 1)) : idx_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      count    <= '0;
      tc       <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      idx      <= idx_next;
      count    <= count_next;
      tc       <= tc_next;
      wrap     <= wrap_next;
      load_err <= err_next;
    end
  end

endmodule

// File: tb/tb_counter_multimode.sv
// Directed bench for counter_multimode: an 8-state 3-bit instance and a
// 6-state 4-bit instance; expectations follow COUNTER_SAT_EN when defined.
module tb_counter_multimode;

  logic       clk = 1'b0;
  logic       reset;

  logic       en_a, load_a;
  logic [1:0] mode_a;
  logic [2:0] load_val_a, count_a;
  logic       tc_a, wrap_a, load_err_a;

  logic       en_b, load_b;
  logic [1:0] mode_b;
  logic [3:0] load_val_b, count_b;
  logic       tc_b, wrap_b, load_err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_multimode #(.WIDTH(3), .MOD_VALUE(8)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .mode(mode_a),
    .load(load_a), .load_val(load_val_a), .count(count_a),
    .tc(tc_a), .wrap(wrap_a), .load_err(load_err_a)
  );

  counter_multimode #(.WIDTH(4), .MOD_VALUE(6)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .mode(mode_b),
    .load(load_b), .load_val(load_val_b), .count(count_b),
    .tc(tc_b), .wrap(wrap_b), .load_err(load_err_b)
  );

  // Outputs are sampled 1ns after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    en_a = 0; load_a = 0; mode_a = 2'b00; load_val_a = '0;
    en_b = 0; load_b = 0; mode_b = 2'b00; load_val_b = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] oa;
    logic [6:0] ob;
    apply_reset();
    reset = 1'b1;
    #1;
    oa = {count_a, tc_a, wrap_a, load_err_a};
    ob = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (oa !== 6'b000_000) begin
      errors++;
      $display("FAIL reset_a: got %b want 000000", oa);
    end
    checks++;
    if (ob !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_b: got %b want 0000000", ob);
    end
    reset = 1'b0;
  endtask

  task automatic test_bin_up();
    logic [2:0] ec[9];
    logic       et[9];
    logic       ew[9];
    logic [4:0] o, e;
`ifdef COUNTER_SAT_EN
    ec = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    et = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    ec = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    et = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    ew = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif
    apply_reset();
    mode_a = 2'b00;
    en_a   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      o = {count_a, tc_a, wrap_a};
      e = {ec[i], et[i], ew[i]};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bin_up[%0d]: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_gray_down();
    logic [2:0] ec[9];
    logic       et[9];
    logic       ew[9];
    logic [4:0] o, e;
    logic [2:0] prev;
`ifdef COUNTER_SAT_EN
    ec = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    et = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    ec = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010,
           3'b011, 3'b001, 3'b000, 3'b100};
    et = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    ew = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
`endif
    apply_reset();
    mode_a = 2'b11;
    en_a   = 1'b1;
    prev   = 3'b000;
    for (int i = 0; i < 9; i++) begin
      tick();
      o = {count_a, tc_a, wrap_a};
      e = {ec[i], et[i], ew[i]};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gray_down[%0d]: got %b want %b", i, o, e);
      end
`ifndef COUNTER_SAT_EN
      checks++;
      if ($countones(prev ^ count_a) != 1) begin
        errors++;
        $display("FAIL gray_step[%0d]: got %b->%b want 1 bit change",
                 i, prev, count_a);
      end
`endif
      prev = count_a;
    end
  endtask

  task automatic test_load_err();
    logic [3:0] ec[6];
    logic       et[6];
    logic       ew[6];
    logic [6:0] o, e;
`ifdef COUNTER_SAT_EN
    ec = '{4, 3, 2, 1, 0, 0};
    et = '{0, 0, 0, 0, 1, 1};
    ew = '{0, 0, 0, 0, 0, 0};
`else
    ec = '{4, 3, 2, 1, 0, 5};
    et = '{0, 0, 0, 0, 1, 0};
    ew = '{0, 0, 0, 0, 0, 1};
`endif
    apply_reset();
    mode_b     = 2'b01;
    load_b     = 1'b1;
    load_val_b = 4'd9;
    tick();
    o = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (o !== 7'b0101_001) begin
      errors++;
      $display("FAIL load_clamp: got %b want 0101001", o);
    end
    load_b = 1'b0;
    en_b   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      o = {count_b, tc_b, wrap_b, load_err_b};
      e = {ec[i], et[i], ew[i], 1'b0};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_down[%0d]: got %b want %b", i, o, e);
      end
    end
    // Jump across the boundary by load: no wrap
    mode_b     = 2'b00;
    load_b     = 1'b1;
    load_val_b = 4'd0;
    tick();
    o = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (o !== 7'b0000_000) begin
      errors++;
      $display("FAIL load_zero: got %b want 0000000", o);
    end
    load_val_b = 4'd5;
    tick();
    o = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (o !== 7'b0101_100) begin
      errors++;
      $display("FAIL load_last: got %b want 0101100", o);
    end
    load_val_b = 4'd6;
    tick();
    o = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (o !== 7'b0101_101) begin
      errors++;
      $display("FAIL load_mod: got %b want 0101101", o);
    end
    load_b = 1'b0;
    en_b   = 1'b0;
    tick();
    o = {count_b, tc_b, wrap_b, load_err_b};
    checks++;
    if (o !== 7'b0101_100) begin
      errors++;
      $display("FAIL err_pulse: got %b want 0101100", o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    mode_a = 2'b00;
    en_a   = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (count_a !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset: got %0d want 3", count_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({count_a, tc_a, wrap_a} !== 5'b000_00) begin
      errors++;
      $display("FAIL async_reset: got %b want 00000",
               {count_a, tc_a, wrap_a});
    end
    #1 reset = 1'b0;
    tick();
    checks++;
    if (count_a !== 3'd1) begin
      errors++;
      $display("FAIL post_reset: got %0d want 1", count_a);
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    mode_a = 2'b00;
    en_a   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (count_a !== 3'd5) begin
      errors++;
      $display("FAIL pre_switch: got %0d want 5", count_a);
    end
    mode_a = 2'b10;
    tick();
    checks++;
    if ({count_a, tc_a} !== 4'b101_0) begin
      errors++;
      $display("FAIL gray_switch: got %b want 1010", {count_a, tc_a});
    end
    en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({count_a, tc_a, wrap_a} !== 5'b101_00) begin
        errors++;
        $display("FAIL hold[%0d]: got %b want 10100",
                 i, {count_a, tc_a, wrap_a});
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mode_a = 2'b00;
    en_a   = 1'b1;
    tick();
    load_a     = 1'b1;
    load_val_a = 3'd4;
    tick();
    checks++;
    if ({count_a, load_err_a} !== 4'b100_0) begin
      errors++;
      $display("FAIL load_pri: got %b want 1000", {count_a, load_err_a});
    end
    tick();
    checks++;
    if (count_a !== 3'd4) begin
      errors++;
      $display("FAIL load_no_step: got %0d want 4", count_a);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] ec[4];
    logic       et[4];
    logic       ew[4];
    logic [4:0] o, e;
`ifdef COUNTER_SAT_EN
    ec = '{7, 7, 7, 7};
    et = '{1, 1, 1, 1};
    ew = '{0, 0, 0, 0};
`else
    ec = '{7, 0, 1, 2};
    et = '{1, 0, 0, 0};
    ew = '{0, 1, 0, 0};
`endif
    apply_reset();
    mode_a     = 2'b00;
    load_a     = 1'b1;
    load_val_a = 3'd6;
    tick();
    checks++;
    if (count_a !== 3'd6) begin
      errors++;
      $display("FAIL sat_load: got %0d want 6", count_a);
    end
    load_a = 1'b0;
    en_a   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      o = {count_a, tc_a, wrap_a};
      e = {ec[i], et[i], ew[i]};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat_up[%0d]: got %b want %b", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bin_up();
    test_gray_down();
    test_load_err();
    test_async_reset();
    test_mode_switch();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
